// File: rtl/vga_timing_generator_pkg.sv
// Shared VGA timing types: packed colour, pattern selector and colour-bar palette.
// Also imported by monitor-side benches.
package vga_timing_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        PAT_EXT   = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_SOLID = 2'd3
    } pattern_t;

    localparam rgb_t RGB_WHITE   = 24'hFFFFFF;
    localparam rgb_t RGB_YELLOW  = 24'hFFFF00;
    localparam rgb_t RGB_CYAN    = 24'h00FFFF;
    localparam rgb_t RGB_GREEN   = 24'h00FF00;
    localparam rgb_t RGB_MAGENTA = 24'hFF00FF;
    localparam rgb_t RGB_RED     = 24'hFF0000;
    localparam rgb_t RGB_BLUE    = 24'h0000FF;
    localparam rgb_t RGB_BLACK   = 24'h000000;

    // Bars run left to right in descending luminance.
    function automatic rgb_t bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return RGB_WHITE;
            3'd1:    return RGB_YELLOW;
            3'd2:    return RGB_CYAN;
            3'd3:    return RGB_GREEN;
            3'd4:    return RGB_MAGENTA;
            3'd5:    return RGB_RED;
            3'd6:    return RGB_BLUE;
            default: return RGB_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vga_timing_generator_if.sv
// Pixel-side bundle of the VGA timing generator: frame control, fetch port and pin outputs.
// The generator is master; the frame source and monitor side use slave.
interface vga_timing_generator_if;

    logic        enable;
    logic [1:0]  pattern_sel;
    logic        pix_req;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    logic [23:0] pix_rgb;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic        frame_start;
    logic        busy;

    modport master (
        input  enable, pattern_sel, pix_rgb,
        output pix_req, pix_x, pix_y, r, g, b, hsync, vsync, de, frame_start, busy
    );

    modport slave (
        output enable, pattern_sel, pix_rgb,
        input  pix_req, pix_x, pix_y, r, g, b, hsync, vsync, de, frame_start, busy
    );

endinterface

// File: rtl/vga_timing_generator_pattern_gen.sv
// Combinational built-in test pattern source; the parent registers the result.
// Only y[3] matters here, so just that bit is passed in.
module vga_pattern_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned HOR_ACT = 640
) (
    input  logic [10:0] x_i,
    input  logic        row_sel_i,
    input  pattern_t    pattern_i,
    output rgb_t        rgb_o
);

    localparam int unsigned BAR_W = HOR_ACT / 8;

    logic [2:0] bar_idx;

    // Bar index from compares against constant multiples; the last bar keeps the remainder.
    always_comb begin
        bar_idx = '0;
        for (int unsigned k = 1; k < 8; k++) begin
            if ({21'b0, x_i} >= k * BAR_W) begin
                bar_idx = 3'(k);
            end
        end
    end

    always_comb begin
        rgb_o = RGB_BLACK;
        case (pattern_i)
            PAT_BARS:  rgb_o = bar_colour(bar_idx);
            PAT_CHECK: rgb_o = (x_i[3] ^ row_sel_i) ? RGB_BLACK : RGB_WHITE;
            PAT_SOLID: rgb_o = RGB_WHITE;
            default:   rgb_o = RGB_BLACK;
        endcase
    end

endmodule

// File: rtl/vga_timing_generator.sv
// VESA-style timing generator with a fixed-latency pixel fetch port and built-in test patterns.
// Stage 0 counters, stage 1 request/decoded timing, stage 2 pins; every pin is two cycles behind the counters.
module vga_timing_generator
    import vga_timing_pkg::*;
#(
    parameter int unsigned HOR_ACT   = 640,
    parameter int unsigned HOR_FP    = 16,
    parameter int unsigned HOR_SYNC  = 96,
    parameter int unsigned HOR_BP    = 48,
    parameter int unsigned VERT_ACT  = 480,
    parameter int unsigned VERT_FP   = 11,
    parameter int unsigned VERT_SYNC = 2,
    parameter int unsigned VERT_BP   = 31
) (
    input  logic                          pixel_clk,
    input  logic                          rst,
    vga_timing_generator_if.master        vga
);

    localparam int unsigned H_TOTAL = HOR_ACT + HOR_FP + HOR_SYNC + HOR_BP;
    localparam int unsigned V_TOTAL = VERT_ACT + VERT_FP + VERT_SYNC + VERT_BP;

    if (H_TOTAL > 2048 || V_TOTAL > 1024) begin : g_bad_timing
        $error("vga_timing_generator: H_TOTAL must be <= 2048 and V_TOTAL <= 1024");
    end

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [10:0] h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    pattern_t    pat_q, pat_d;

    logic running, frame_first, frame_end;
    logic h_act, v_act, h_sync_zone, v_sync_zone;

    assign running     = (state_q != ST_IDLE);
    assign frame_first = running && (h_cnt_q == '0) && (v_cnt_q == '0);
    assign frame_end   = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

    assign h_act       = 32'(h_cnt_q) < HOR_ACT;
    assign v_act       = 32'(v_cnt_q) < VERT_ACT;
    assign h_sync_zone = (32'(h_cnt_q) >= HOR_ACT + HOR_FP) &&
                         (32'(h_cnt_q) <  HOR_ACT + HOR_FP + HOR_SYNC);
    assign v_sync_zone = (32'(v_cnt_q) >= VERT_ACT + VERT_FP) &&
                         (32'(v_cnt_q) <  VERT_ACT + VERT_FP + VERT_SYNC);

    // Dropping enable on the very last pixel goes straight to IDLE rather than running one more frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (vga.enable) state_d = ST_RUN;
            ST_RUN:  if (!vga.enable) state_d = frame_end ? ST_IDLE : ST_STOP;
            ST_STOP: begin
                if (vga.enable)     state_d = ST_RUN;
                else if (frame_end) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (running) begin
            h_cnt_d = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + 11'd1;
            v_cnt_d = v_cnt_q;
            if (h_cnt_q == H_LAST) begin
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
            end
        end
    end

    // The first pixel of a frame already uses the freshly sampled selector.
    assign pat_d = frame_first ? pattern_t'(vga.pattern_sel) : pat_q;

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            pat_q   <= PAT_EXT;
        end else begin
            state_q <= state_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            pat_q   <= pat_d;
        end
    end

    logic        pix_req_q, de1_q, hs1_q, vs1_q, fs1_q;
    logic [10:0] pix_x_q;
    logic [9:0]  pix_y_q;
    pattern_t    pat1_q;

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            pix_req_q <= 1'b0;
            pix_x_q   <= '0;
            pix_y_q   <= '0;
            de1_q     <= 1'b0;
            hs1_q     <= 1'b1;
            vs1_q     <= 1'b1;
            fs1_q     <= 1'b0;
            pat1_q    <= PAT_EXT;
        end else begin
            pix_req_q <= running && h_act && v_act && (pat_d == PAT_EXT);
            pix_x_q   <= h_cnt_q;
            pix_y_q   <= v_cnt_q;
            de1_q     <= running && h_act && v_act;
            hs1_q     <= !(running && h_sync_zone);
            vs1_q     <= !(running && v_sync_zone);
            fs1_q     <= frame_first;
            pat1_q    <= pat_d;
        end
    end

    rgb_t pat_rgb;

    vga_pattern_gen #(
        .HOR_ACT (HOR_ACT)
    ) u_pattern (
        .x_i       (pix_x_q),
        .row_sel_i (pix_y_q[3]),
        .pattern_i (pat1_q),
        .rgb_o     (pat_rgb)
    );

    rgb_t rgb_q;
    logic hs_q, vs_q, de_q, fs_q;

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            rgb_q <= '0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            de_q  <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            if (!de1_q)                rgb_q <= '0;
            else if (pat1_q == PAT_EXT) rgb_q <= vga.pix_rgb;
            else                        rgb_q <= pat_rgb;
            hs_q <= hs1_q;
            vs_q <= vs1_q;
            de_q <= de1_q;
            fs_q <= fs1_q;
        end
    end

    assign vga.pix_req     = pix_req_q;
    assign vga.pix_x       = pix_x_q;
    assign vga.pix_y       = pix_y_q;
    assign vga.r           = rgb_q.r;
    assign vga.g           = rgb_q.g;
    assign vga.b           = rgb_q.b;
    assign vga.hsync       = hs_q;
    assign vga.vsync       = vs_q;
    assign vga.de          = de_q;
    assign vga.frame_start = fs_q;
    assign vga.busy        = running;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: small-timing instance against a frame-position model,
// plus a 640-wide instance for colour-bar boundaries.
module tb_vga_timing_generator;
    import vga_timing_pkg::*;

    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vga_timing_generator_if sif ();
    vga_timing_generator_if bif ();

    logic [23:0] key;
    assign sif.pix_rgb = {3'b000, sif.pix_x, sif.pix_y} ^ key;
    assign bif.pix_rgb = '0;

    vga_timing_generator #(
        .HOR_ACT (HA), .HOR_FP (HF), .HOR_SYNC (HS), .HOR_BP (HB),
        .VERT_ACT (VA), .VERT_FP (VF), .VERT_SYNC (VS), .VERT_BP (VB)
    ) dut (
        .pixel_clk (clk),
        .rst       (rst),
        .vga       (sif)
    );

    vga_timing_generator big (
        .pixel_clk (clk),
        .rst       (rst),
        .vga       (bif)
    );

    int checks = 0;
    int errors = 0;
    int pats [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] bar_rgb(input int x, input int ha);
        int idx;
        idx = x / (ha / 8);
        if (idx > 7) idx = 7;
        case (idx)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [23:0] pixel_rgb(input int pat, input int h, input int v);
        logic [10:0] hx;
        logic [9:0]  vy;
        hx = 11'(h);
        vy = 10'(v);
        case (pat)
            0:       return {3'b000, hx, vy} ^ key;
            1:       return bar_rgb(h, HA);
            2:       return ((((h / 8) + (v / 8)) % 2) == 0) ? 24'hFFFFFF : 24'h000000;
            default: return 24'hFFFFFF;
        endcase
    endfunction

    // Cycle c counts from the first cycle the counters sit at (0,0); pins show position c-2.
    task automatic check_cycle(input int c, input int n);
        int k, f, pos, h, v;
        logic e_hs, e_vs, e_de, e_fs, e_req, e_busy;
        logic [23:0] e_rgb;
        logic [10:0] e_x;
        logic [9:0]  e_y;
        e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_fs = 1'b0; e_rgb = '0;
        k = c - 2;
        if (k >= 0 && k < n * FT) begin
            f = k / FT; pos = k % FT; h = pos % HT; v = pos / HT;
            e_de  = (h < HA) && (v < VA);
            e_hs  = !((h >= HA + HF) && (h < HA + HF + HS));
            e_vs  = !((v >= VA + VF) && (v < VA + VF + VS));
            e_fs  = (pos == 0);
            e_rgb = e_de ? pixel_rgb(pats[f], h, v) : 24'h000000;
        end
        e_req = 1'b0; e_x = '0; e_y = '0;
        k = c - 1;
        if (k >= 0 && k < n * FT) begin
            f = k / FT; pos = k % FT; h = pos % HT; v = pos / HT;
            e_x   = 11'(h);
            e_y   = 10'(v);
            e_req = (h < HA) && (v < VA) && (pats[f] == 0);
        end
        e_busy = (c < n * FT);
        chk("hsync", 32'(sif.hsync), 32'(e_hs));
        chk("vsync", 32'(sif.vsync), 32'(e_vs));
        chk("de", 32'(sif.de), 32'(e_de));
        chk("frame_start", 32'(sif.frame_start), 32'(e_fs));
        chk("rgb", 32'({sif.r, sif.g, sif.b}), 32'(e_rgb));
        chk("pix_req", 32'(sif.pix_req), 32'(e_req));
        chk("pix_x", 32'(sif.pix_x), 32'(e_x));
        chk("pix_y", 32'(sif.pix_y), 32'(e_y));
        chk("busy", 32'(sif.busy), 32'(e_busy));
    endtask

    task automatic run_frames(input int n, input int drop_at);
        @(negedge clk);
        sif.enable      = 1'b1;
        sif.pattern_sel = 2'(pats[0]);
        for (int c = 0; c <= n * FT + 3; c++) begin
            @(negedge clk);
            check_cycle(c, n);
            for (int f = 0; f < n; f++) begin
                if (c == f * FT + 50) begin
                    sif.pattern_sel = (f + 1 < n) ? 2'(pats[f + 1]) : 2'($urandom);
                end
            end
            if (c == drop_at) sif.enable = 1'b0;
        end
    endtask

    task automatic check_idle_pins(input string tag);
        chk({tag, "_hsync"}, 32'(sif.hsync), 32'd1);
        chk({tag, "_vsync"}, 32'(sif.vsync), 32'd1);
        chk({tag, "_de"}, 32'(sif.de), 32'd0);
        chk({tag, "_rgb"}, 32'({sif.r, sif.g, sif.b}), 32'd0);
        chk({tag, "_pix_req"}, 32'(sif.pix_req), 32'd0);
        chk({tag, "_frame_start"}, 32'(sif.frame_start), 32'd0);
        chk({tag, "_busy"}, 32'(sif.busy), 32'd0);
    endtask

    initial begin
        int n;
        rst             = 1'b1;
        key             = '0;
        sif.enable      = 1'b0;
        sif.pattern_sel = 2'd0;
        bif.enable      = 1'b0;
        bif.pattern_sel = 2'd0;
        repeat (3) @(negedge clk);
        check_idle_pins("reset");
        chk("reset_pix_x", 32'(sif.pix_x), 32'd0);
        chk("reset_pix_y", 32'(sif.pix_y), 32'd0);
        rst = 1'b0;

        // Colour bars at 640 wide: one-cycle enable pulse, first line checked pixel by pixel.
        @(negedge clk);
        bif.enable      = 1'b1;
        bif.pattern_sel = 2'd1;
        for (int c = 0; c < 642; c++) begin
            @(negedge clk);
            if (c == 0) bif.enable = 1'b0;
            if (c >= 2) begin
                chk("bars_de", 32'(bif.de), 32'd1);
                chk("bars_rgb", 32'({bif.r, bif.g, bif.b}), 32'(bar_rgb(c - 2, 640)));
            end
        end
        chk("bars_pix_req", 32'(bif.pix_req), 32'd0);

        // External source, two frames, enable dropped mid second frame.
        key = 24'($urandom);
        pats[0] = 0; pats[1] = 0;
        run_frames(2, FT + 30);

        // Selector changed mid-frame: bars then checkerboard.
        pats[0] = 1; pats[1] = 2;
        run_frames(2, FT + 70);

        // Single-cycle enable pulse still yields one full frame.
        pats[0] = int'($urandom_range(0, 3));
        run_frames(1, 0);

        for (int r = 0; r < 4; r++) begin
            key = 24'($urandom);
            n = int'($urandom_range(1, 3));
            for (int f = 0; f < 4; f++) pats[f] = int'($urandom_range(0, 3));
            run_frames(n, (n - 1) * FT + int'($urandom_range(0, FT - 1)));
        end

        // Reset in the middle of an active line.
        pats[0] = 3;
        @(negedge clk);
        sif.enable      = 1'b1;
        sif.pattern_sel = 2'd3;
        repeat (21) @(negedge clk);
        chk("midrst_pre_de", 32'(sif.de), 32'd1);
        chk("midrst_pre_rgb", 32'({sif.r, sif.g, sif.b}), 32'hFFFFFF);
        rst        = 1'b1;
        sif.enable = 1'b0;
        @(negedge clk);
        check_idle_pins("midrst");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_pins("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_generator.md
# vga_timing_generator

Video timing and pixel source for the virtual devboard VGA path. Generates VESA-style hsync/vsync/data-enable from programmable parameters, fetches pixels from an external frame source through a fixed-latency request port, or substitutes a built-in test pattern. Sits directly upstream of the VGA monitor model and drives its r, g, b, hsync and vsync inputs, clocked by the same pixel clock.

## Interface
- HOR_ACT, 640, active pixels per line
- HOR_FP, 16, horizontal front porch (pixels)
- HOR_SYNC, 96, hsync pulse width (pixels)
- HOR_BP, 48, horizontal back porch (pixels)
- VERT_ACT, 480, active lines per frame
- VERT_FP, 11, vertical front porch (lines)
- VERT_SYNC, 2, vsync pulse width (lines)
- VERT_BP, 31, vertical back porch (lines)
- pixel_clk  in  1  pixel clock; sole clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  start/keep generating frames; deassert = stop at end of current frame
- pattern_sel  in  2  0 external, 1 colour bars, 2 checkerboard, 3 solid white; sampled at frame start only
- pix_req  out  1  registered; pixel wanted at (pix_x, pix_y)
- pix_x  out  11  registered column of request
- pix_y  out  10  registered line of request
- pix_rgb  in  24  {r,g,b} from source, valid exactly 1 cycle after pix_req
- r, g, b  out  8 each  registered colour; 0 outside active video
- hsync, vsync  out  1 each  registered, active-low
- de  out  1  registered data enable
- frame_start  out  1  one-cycle pulse with first active pixel of each frame
- busy  out  1  state != IDLE

## Operation
- Constants: H_TOTAL = sum of HOR_*, V_TOTAL = sum of VERT_*; elaboration error if H_TOTAL > 2048 or V_TOTAL > 1024.
- Line order: active, front porch, sync, back porch. Frame order identical in lines.
- h_cnt 0..H_TOTAL-1, wraps to 0; v_cnt increments when h_cnt wraps, wraps to 0 after V_TOTAL-1.
- h_act = h_cnt < HOR_ACT; hsync low when HOR_ACT+HOR_FP <= h_cnt < HOR_ACT+HOR_FP+HOR_SYNC. Same form for v_act/vsync on v_cnt.
- FSM: IDLE -> RUN when enable=1 (counters start at 0,0 next cycle); RUN -> STOPPING when enable=0; STOPPING -> RUN if enable re-asserts before frame end; STOPPING -> IDLE when h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1. In IDLE counters hold 0, hsync/vsync high, de/pix_req low.
- pattern latched into pat_q when h_cnt=0, v_cnt=0 and not IDLE.
- pix_req = h_act & v_act & pat_q==0 (external only); pix_x/pix_y = h_cnt/v_cnt.
- Patterns: bars = 8 equal bars of width HOR_ACT/8 (last bar absorbs remainder), order white, yellow, cyan, green, magenta, red, blue, black; checkerboard 8x8 squares, white where (x[3]^y[3])=0 else black; solid = FFFFFF.
- Arithmetic: counters unsigned, no saturation; bar index via compare against multiples, no divider.

## Timing
- Reset values: hsync=1, vsync=1, de=0, r=g=b=0, pix_req=0, pix_x=0, pix_y=0, frame_start=0, busy=0, state IDLE, counters 0.
- Pipeline: stage 0 counters; stage 1 pix_req/pix_x/pix_y and delayed syncs/de; stage 2 pins. Pin latency from counter = 2 cycles for all outputs, so sync/de/rgb stay mutually aligned.
- pix_rgb sampled in the cycle after pix_req; no back-pressure, source must meet latency.
- Pattern pixels computed in stage 1, registered to pins in stage 2 (same alignment).
- vsync edges coincide with hsync-line boundary (h_cnt=0 at stage 0).
- rst mid-frame: all outputs return to reset values next cycle; no partial-frame recovery.
- enable toggling in IDLE for one cycle still starts a full frame.

## Structure
- Package vga_timing_pkg: rgb_t (packed r,g,b), pattern_t enum, colour-bar constants; shared with monitor-side testbenches.
- Sub-module vga_pattern_gen: combinational x,y,pattern -> rgb_t, registered in the parent.

## Test plan
Sim parameters: HOR 8/2/3/2 (H_TOTAL 15), VERT 4/1/2/1 (V_TOTAL 8).
- rst then enable=1, pattern 0 -> pix_req high 8 cycles per line, 4 lines; hsync low 3 cycles starting 10 cycles after line start; period 15; frame 120 cycles.
- pix_rgb = {pix_x, pix_y} echo source -> r,g,b at pins match requested coordinates with de=1, exactly 1 cycle after source data.
- pattern 1 at HOR_ACT=640 -> bars change at x=80,160..560; x=0 FFFFFF, x=639 000000.
- enable dropped mid-frame 0 -> frame completes, busy falls after v=7,h=14; no second frame_start.
- pattern_sel changed mid-frame 1->2 -> current frame stays bars, next frame checkerboard.
- rst asserted mid-active line -> next cycle hsync=vsync=1, de=0, rgb=0, busy=0.
